rv_iommu_mem_rd_arb: RTL and testbench
======================================

RV_IOMMU_MEM_RD_ARB -- requirements
Module: rv_iommu_mem_rd_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters (PTW, CDW, CQ handler, MSI-PTW); legal range 1..8.
REQ-002 Parameter ADDR_WIDTH, default 64: read address width.
REQ-003 Parameter DATA_WIDTH, default 64: read data width.
REQ-004 Parameter IDW, default max(1,clog2(N_REQ)): width of the ID driven on the memory port.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  N_REQ  per-requester read request valid.
REQ-008 req_ready_o  out  N_REQ  per-requester request accepted.
REQ-009 req_addr_i  in  N_REQ*ADDR_WIDTH  packed request addresses, requester k at slice k.
REQ-010 req_len_i  in  N_REQ*8  packed AXI burst lengths (beats-1).
REQ-011 rsp_valid_o  out  N_REQ  per-requester read beat valid.
REQ-012 rsp_ready_i  in  N_REQ  per-requester read beat ready.
REQ-013 rsp_data_o  out  DATA_WIDTH  shared read data to all requesters.
REQ-014 rsp_last_o / rsp_err_o  out  1 each  last beat; beat error.
REQ-015 ar_valid_o / ar_ready_i  out/in  1 each  memory AR handshake.
REQ-016 ar_addr_o / ar_len_o / ar_id_o  out  ADDR_WIDTH / 8 / IDW  AR payload.
REQ-017 r_valid_i / r_ready_o  in/out  1 each  memory R handshake.
REQ-018 r_data_i / r_resp_i / r_last_i / r_id_i  in  DATA_WIDTH / 2 / 1 / IDW  R payload.
REQ-019 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, ADDR, DATA; one outstanding burst at a time.
REQ-021 IDLE: if any req_valid_i, winner = first k with req_valid_i[k] searching from rr_ptr upward, wrapping at N_REQ.
REQ-022 IDLE with winner: req_ready_o[winner]=1 that cycle only; latch addr, len, owner=winner; next state ADDR.
REQ-023 req_ready_o is 0 for all requesters in ADDR and DATA, and for non-winners in IDLE.
REQ-024 ADDR: ar_valid_o=1, ar_addr_o/ar_len_o latched values, ar_id_o=owner; payload stable until ar_ready_i.
REQ-025 ADDR with ar_ready_i=1: next state DATA; ar_valid_o low from next cycle.
REQ-026 Latency: request handshake at cycle N -> ar_valid_o first high at N+1.
REQ-027 DATA: rsp_valid_o[owner]=r_valid_i, other bits 0; r_ready_o=rsp_ready_i[owner]; rsp_data_o=r_data_i, rsp_last_o=r_last_i, combinational (zero latency).
REQ-028 rsp_err_o = r_resp_i[1] OR (r_id_i != owner), per beat.
REQ-029 DATA with r_valid_i & r_ready_o & r_last_i: next state IDLE; rr_ptr = (owner+1) mod N_REQ.
REQ-030 r_ready_o=0 and all rsp_valid_o=0 in IDLE and ADDR; R beats there are stalled, never dropped.
REQ-031 Minimum one IDLE cycle between consecutive bursts; no back-to-back AR.
REQ-032 Requester dropping req_valid_i before its req_ready_o: no effect; arbitration re-evaluated each IDLE cycle.
REQ-033 rr_ptr updates only on burst completion; N_REQ=1 holds rr_ptr at 0.
REQ-034 rsp_data_o/rsp_last_o/rsp_err_o are don't-care outside DATA; drive 0.

Reset
REQ-035 rst_ni low: immediately (no clock) state=IDLE, rr_ptr=0, latched addr/len/owner=0.
REQ-036 During reset, all outputs 0: req_ready_o, rsp_valid_o, ar_valid_o, r_ready_o, busy_o, payloads.
REQ-037 Reset mid-ADDR or mid-DATA abandons the burst; first cycle after release is IDLE with rr_ptr=0.

Verification
REQ-038 Single request: req_valid_i=0b0010, addr 0x8000_1000, len 0 -> req_ready_o=0b0010 cycle 0, ar_valid_o cycle 1 with ar_id_o=1, one beat to requester 1, then rr_ptr=2.
REQ-039 Fairness: all four req_valid_i held high, len 3 each -> grant order 0,1,2,3,0; each burst 4 beats routed to correct requester only.
REQ-040 Backpressure: ar_ready_i low 5 cycles, rsp_ready_i[owner] toggling -> AR payload stable, no beat lost or duplicated, r_ready_o mirrors rsp_ready_i[owner].
REQ-041 Errors: r_resp_i=2'b10 on beat 2, then a burst with r_id_i != owner -> rsp_err_o=1 on exactly those beats; FSM still returns to IDLE on last.
REQ-042 Reset in DATA after beat 1 of 4 -> all outputs 0 asynchronously; after release, pending req_valid_i=0b0100 granted to requester 2 (search from rr_ptr=0).
REQ-043 Early R: r_valid_i high during IDLE/ADDR -> r_ready_o=0, rsp_valid_o=0 until DATA.

Source files
------------

// File: rtl/rv_iommu_mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : rv_iommu_mem_rd_arb
// Brief    : Round-robin arbiter sharing one AXI-style read port among the
//            IOMMU read requesters, one outstanding burst at a time.
// Revision : 1.0 - initial release
// ============================================================================
module rv_iommu_mem_rd_arb #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*8-1:0]          req_len_i,

    output logic [N_REQ-1:0]            rsp_valid_o,
    input  logic [N_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       rsp_data_o,
    output logic                        rsp_last_o,
    output logic                        rsp_err_o,

    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [ADDR_WIDTH-1:0]       ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [IDW-1:0]              ar_id_o,

    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [DATA_WIDTH-1:0]       r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic [IDW-1:0]              r_id_i,

    output logic                        busy_o
);

    localparam int C_PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int C_PW1 = C_PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                r_state;
    logic [C_PW-1:0]       r_rr_ptr;
    logic [C_PW-1:0]       r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;

    logic                  w_idle;
    logic                  w_in_data;
    logic                  w_found;
    logic [C_PW-1:0]       w_winner;
    logic [C_PW-1:0]       w_idx;
    logic [C_PW1-1:0]      w_sum;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [7:0]            w_win_len;
    logic [C_PW-1:0]       w_next_ptr;
    logic                  w_unused_resp0;

    assign w_idle         = (r_state == ST_IDLE);
    assign w_in_data      = (r_state == ST_DATA);
    assign w_unused_resp0 = r_resp_i[0];

    // Walk downward so the lowest rotated offset (closest to rr_ptr) wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + C_PW1'(i);
            if (w_sum >= C_PW1'(N_REQ)) begin
                w_sum = w_sum - C_PW1'(N_REQ);
            end
            w_idx = w_sum[C_PW-1:0];
            if (req_valid_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_addr = '0;
        w_win_len  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_winner == C_PW'(k)) begin
                w_win_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_len  = req_len_i[k*8 +: 8];
            end
        end
    end

    assign w_next_ptr = (r_owner == C_PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Grant is gated by rst_ni so nothing is acknowledged while reset is held.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = rst_ni & w_idle & w_found & (w_winner == C_PW'(k));
            rsp_valid_o[k] = w_in_data & r_valid_i & (r_owner == C_PW'(k));
        end
    end

    assign r_ready_o  = w_in_data & rsp_ready_i[r_owner];
    assign rsp_data_o = w_in_data ? r_data_i : '0;
    assign rsp_last_o = w_in_data & r_last_i;
    assign rsp_err_o  = w_in_data & (r_resp_i[1] | (r_id_i != IDW'(r_owner)));

    assign ar_valid_o = (r_state == ST_ADDR);
    assign ar_addr_o  = r_addr;
    assign ar_len_o   = r_len;
    assign ar_id_o    = IDW'(r_owner);
    assign busy_o     = ~w_idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_addr   <= '0;
            r_len    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_addr  <= w_win_addr;
                        r_len   <= w_win_len;
                        r_owner <= w_winner;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_ready_i) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_valid_i && r_ready_o && r_last_i) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_iommu_mem_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_iommu_mem_rd_arb
// Brief    : Directed self-checking bench for the IOMMU memory read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_iommu_mem_rd_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [255:0] req_addr;
    logic [31:0]  req_len;
    logic [63:0]  rsp_data;
    logic         rsp_last, rsp_err;
    logic         ar_valid, ar_ready;
    logic [63:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [1:0]   ar_id;
    logic         r_valid, r_ready;
    logic [63:0]  r_data;
    logic [1:0]   r_resp;
    logic         r_last;
    logic [1:0]   r_id;
    logic         busy;

    logic [63:0]  addr_tab [4];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    rv_iommu_mem_rd_arb #(
        .N_REQ(4), .ADDR_WIDTH(64), .DATA_WIDTH(64), .IDW(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .ar_addr_o(ar_addr), .ar_len_o(ar_len), .ar_id_o(ar_id),
        .r_valid_i(r_valid), .r_ready_o(r_ready),
        .r_data_i(r_data), .r_resp_i(r_resp), .r_last_i(r_last), .r_id_i(r_id),
        .busy_o(busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered in the IDLE low phase with req_valid already driven.
    task automatic run_burst(input int own, input int beats, input int err_beat,
                             input bit bad_id, input int ar_stall, input bit toggle,
                             input bit hold);
        logic [3:0] oh;
        logic [1:0] own2;
        int         beat;
        int         guard;
        bit         rdy;
        oh   = 4'b0001 << own;
        own2 = own[1:0];
        #1 check_val("req_ready_grant", req_ready, oh);
        @(posedge clk); @(negedge clk);
        if (!hold) req_valid[own] = 1'b0;
        for (int s = 0; s <= ar_stall; s++) begin
            ar_ready = (s == ar_stall);
            r_valid  = 1'b1;
            #1;
            check_val("ar_valid", ar_valid, 1'b1);
            check_val("ar_addr", ar_addr, addr_tab[own]);
            check_val("ar_len", ar_len, beats - 1);
            check_val("ar_id", ar_id, own2);
            check_val("r_ready_addr", r_ready, 1'b0);
            check_val("rsp_valid_addr", rsp_valid, 4'b0000);
            check_val("req_ready_addr", req_ready, 4'b0000);
            @(posedge clk); @(negedge clk);
        end
        ar_ready = 1'b0;
        beat  = 0;
        guard = 0;
        while (beat < beats && guard < 64) begin
            rdy       = toggle ? (guard % 2 == 1) : 1'b1;
            r_valid   = 1'b1;
            r_data    = {32'hD000_0000 | 32'(own), 32'(beat)};
            r_last    = (beat == beats - 1);
            r_id      = bad_id ? (own2 ^ 2'b01) : own2;
            r_resp    = (beat == err_beat) ? 2'b10 : 2'b00;
            rsp_ready = rdy ? oh : ~oh;
            #1;
            check_val("ar_valid_data", ar_valid, 1'b0);
            check_val("rsp_valid", rsp_valid, oh);
            check_val("r_ready", r_ready, rdy);
            check_val("rsp_data", rsp_data, {32'hD000_0000 | 32'(own), 32'(beat)});
            check_val("rsp_last", rsp_last, beat == beats - 1);
            check_val("rsp_err", rsp_err, bad_id || (beat == err_beat));
            if (rdy) beat++;
            guard++;
            @(posedge clk); @(negedge clk);
        end
        check_val("beats_done", beat, beats);
        r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00; rsp_ready = 4'b0000;
        #1;
        check_val("busy_after_last", busy, 1'b0);
        check_val("rsp_valid_idle", rsp_valid, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        addr_tab[0] = 64'h0000_0000_1000_0000;
        addr_tab[1] = 64'h0000_0000_8000_1000;
        addr_tab[2] = 64'h0000_0000_2000_0040;
        addr_tab[3] = 64'h0000_0000_3000_0080;
        req_addr  = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
        req_len   = '0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        ar_ready  = 1'b0;
        r_valid   = 1'b1;
        r_data    = 64'hFFFF_FFFF_FFFF_FFFF;
        r_resp    = 2'b10;
        r_last    = 1'b1;
        r_id      = 2'b00;

        // Outputs while reset is held, with every input active
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_req_ready", req_ready, 4'b0000);
        check_val("rst_ar_valid", ar_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_r_ready", r_ready, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 4'b0000);
        check_val("rst_ar_addr", ar_addr, 64'h0);
        check_val("rst_rsp_data", rsp_data, 64'h0);
        check_val("rst_rsp_err", rsp_err, 1'b0);
        req_valid = 4'b0000; rsp_ready = 4'b0000; r_valid = 1'b0;
        r_resp = 2'b00; r_last = 1'b0; r_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 1, one beat
        req_valid = 4'b0010;
        run_burst(1, 1, -1, 1'b0, 0, 1'b0, 1'b0);

        // rr_ptr now 2: requester 2 idle, so 3 wins over 0 and 1
        req_valid = 4'b1011;
        run_burst(3, 1, -1, 1'b0, 0, 1'b0, 1'b0);

        // Fairness with everyone requesting, four-beat bursts
        req_len   = {4{8'd3}};
        req_valid = 4'b1111;
        run_burst(0, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        run_burst(1, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        run_burst(2, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        run_burst(3, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        run_burst(0, 4, -1, 1'b0, 0, 1'b0, 1'b1);
        req_valid = 4'b0000;

        // AR backpressure and toggling response ready
        req_valid = 4'b0100;
        run_burst(2, 4, -1, 1'b0, 5, 1'b1, 1'b0);

        // SLVERR on beat 2, then a burst returning the wrong ID
        req_valid = 4'b1000;
        run_burst(3, 4, 2, 1'b0, 0, 1'b0, 1'b0);
        req_valid = 4'b0001;
        run_burst(0, 4, -1, 1'b1, 0, 1'b0, 1'b0);

        // Early R beat while idle is stalled and does not disturb the FSM
        r_valid = 1'b1; r_last = 1'b1; rsp_ready = 4'b1111;
        #1;
        check_val("early_r_ready", r_ready, 1'b0);
        check_val("early_rsp_valid", rsp_valid, 4'b0000);
        @(posedge clk); @(negedge clk);
        #1;
        check_val("early_busy", busy, 1'b0);
        r_valid = 1'b0; r_last = 1'b0; rsp_ready = 4'b0000;

        // rr_ptr is 1: wrap-around grant to 0, then reset mid-DATA
        req_valid = 4'b0001;
        #1 check_val("wrap_grant", req_ready, 4'b0001);
        @(posedge clk); @(negedge clk);
        req_valid = 4'b0000; ar_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        ar_ready = 1'b0; r_valid = 1'b1; rsp_ready = 4'b0001;
        r_data = 64'h1111; r_id = 2'b00; r_last = 1'b0;
        #1 check_val("mid_rsp_valid", rsp_valid, 4'b0001);
        @(posedge clk); @(negedge clk);
        r_data = 64'h2222;
        #1 check_val("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        req_valid = 4'b0100;
        #1;
        check_val("arst_rsp_valid", rsp_valid, 4'b0000);
        check_val("arst_r_ready", r_ready, 1'b0);
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_req_ready", req_ready, 4'b0000);
        check_val("arst_rsp_data", rsp_data, 64'h0);
        check_val("arst_ar_addr", ar_addr, 64'h0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; r_valid = 1'b0; rsp_ready = 4'b0000;
        run_burst(2, 4, -1, 1'b0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
